// File: rtl/tpu_matmul_unit.sv
// tpu_matmul_unit: execute-side matrix-multiply responder.
// Holds DIM x DIM buffers A, B and C. Elements are written one per cycle while
// idle, and a start command runs C = C + A*B with one MAC per cycle.
// Ports:
//   clk_i, rst_n_i           clock, asynchronous active-low reset
//   wr_en_{a,b,c}_i          independent element write strobes (idle only)
//   row_i, col_i, wr_data_i  write address and data; out-of-range writes drop
//   start_i                  begin multiply-accumulate (idle only)
//   rd_row_i, rd_col_i       C read address
//   rd_data_o                registered C element, 0 when out of range
//   busy_o                   high while computing or done (pipeline stall)
//   done_o                   one-cycle pulse in the last busy cycle
module tpu_matmul_unit #(
    parameter int unsigned DIM    = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wr_en_a_i,
    input  logic              wr_en_b_i,
    input  logic              wr_en_c_i,
    input  logic [4:0]        row_i,
    input  logic [4:0]        col_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              start_i,
    input  logic [4:0]        rd_row_i,
    input  logic [4:0]        rd_col_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned IDX_W = 5;
    localparam int unsigned CNT_W = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIM - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_DONE
    } state_e;

    state_e state_q, state_d;
    logic [CNT_W-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             mac_en;
    logic [DATA_W-1:0] rd_data_q;

    logic [DATA_W-1:0] a_q [DIM][DIM];
    logic [DATA_W-1:0] b_q [DIM][DIM];
    logic [DATA_W-1:0] c_q [DIM][DIM];

    // Address decode for the write and read ports
    logic             wr_ok;
    logic             rd_ok;
    logic [CNT_W-1:0] wr_row, wr_col, rd_row, rd_col;
    logic [DATA_W-1:0] mac_sum;

    assign wr_row = row_i[CNT_W-1:0];
    assign wr_col = col_i[CNT_W-1:0];
    assign rd_row = rd_row_i[CNT_W-1:0];
    assign rd_col = rd_col_i[CNT_W-1:0];
    assign wr_ok  = (state_q == S_IDLE) && (row_i < IDX_W'(DIM)) && (col_i < IDX_W'(DIM));
    assign rd_ok  = (rd_row_i < IDX_W'(DIM)) && (rd_col_i < IDX_W'(DIM));

    // Product and sum both truncate to DATA_W (unsigned wrap)
    assign mac_sum = c_q[i_q][j_q] + a_q[i_q][k_q] * b_q[k_q][j_q];

    // State and counter registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state: k innermost, then j, then i
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        mac_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_COMPUTE;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            S_COMPUTE: begin
                mac_en = 1'b1;
                if (k_q == LAST) begin
                    k_d = '0;
                    if (j_q == LAST) begin
                        j_d = '0;
                        if (i_q == LAST) begin
                            i_d     = '0;
                            state_d = S_DONE;
                        end else begin
                            i_d = i_q + CNT_W'(1);
                        end
                    end else begin
                        j_d = j_q + CNT_W'(1);
                    end
                end else begin
                    k_d = k_q + CNT_W'(1);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // A and B buffers: host writes only
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int r = 0; r < int'(DIM); r++) begin
                for (int c = 0; c < int'(DIM); c++) begin
                    a_q[r][c] <= '0;
                    b_q[r][c] <= '0;
                end
            end
        end else if (wr_ok) begin
            if (wr_en_a_i) a_q[wr_row][wr_col] <= wr_data_i;
            if (wr_en_b_i) b_q[wr_row][wr_col] <= wr_data_i;
        end
    end

    // C buffer: MAC updates while computing, host preload while idle
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int r = 0; r < int'(DIM); r++) begin
                for (int c = 0; c < int'(DIM); c++) begin
                    c_q[r][c] <= '0;
                end
            end
        end else if (mac_en) begin
            c_q[i_q][j_q] <= mac_sum;
        end else if (wr_ok && wr_en_c_i) begin
            c_q[wr_row][wr_col] <= wr_data_i;
        end
    end

    // Registered C read port, active in every state
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_ok ? c_q[rd_row][rd_col] : '0;
        end
    end

    assign rd_data_o = rd_data_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_tpu_matmul_unit.sv
// Self-checking bench for tpu_matmul_unit: directed scenarios plus random
// traffic, checked every cycle against a behavioural model of the unit.
module tb_tpu_matmul_unit;

    localparam int DIM = 4;
    localparam int D3  = DIM * DIM * DIM;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b1;
    logic        wr_en_a_i = 1'b0, wr_en_b_i = 1'b0, wr_en_c_i = 1'b0;
    logic [4:0]  row_i = '0, col_i = '0;
    logic [31:0] wr_data_i = '0;
    logic        start_i = 1'b0;
    logic [4:0]  rd_row_i = '0, rd_col_i = '0;
    logic [31:0] rd_data_o;
    logic        busy_o, done_o;

    int vectors = 0;
    int miscompares = 0;

    tpu_matmul_unit #(.DIM(DIM), .DATA_W(32)) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .wr_en_a_i (wr_en_a_i),
        .wr_en_b_i (wr_en_b_i),
        .wr_en_c_i (wr_en_c_i),
        .row_i     (row_i),
        .col_i     (col_i),
        .wr_data_i (wr_data_i),
        .start_i   (start_i),
        .rd_row_i  (rd_row_i),
        .rd_col_i  (rd_col_i),
        .rd_data_o (rd_data_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural model: m_n is -1 when idle, the MAC number while computing,
    // and D3 in the completion cycle.
    logic [31:0] m_a [DIM][DIM];
    logic [31:0] m_b [DIM][DIM];
    logic [31:0] m_c [DIM][DIM];
    int          m_n;
    logic [31:0] exp_rd;
    logic        exp_busy, exp_done;
    bit          model_ok = 1'b0;

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int r = 0; r < DIM; r++)
                for (int c = 0; c < DIM; c++) begin
                    m_a[r][c] = 0; m_b[r][c] = 0; m_c[r][c] = 0;
                end
            m_n      = -1;
            exp_rd   = 0;
            exp_busy = 0;
            exp_done = 0;
            model_ok = 1'b1;
        end else begin
            int rr, rc, wr, wc, mi, mj, mk;
            rr = int'(rd_row_i); rc = int'(rd_col_i);
            exp_rd = (rr < DIM && rc < DIM) ? m_c[rr][rc] : 32'd0;
            if (m_n < 0) begin
                wr = int'(row_i); wc = int'(col_i);
                if (wr < DIM && wc < DIM) begin
                    if (wr_en_a_i) m_a[wr][wc] = wr_data_i;
                    if (wr_en_b_i) m_b[wr][wc] = wr_data_i;
                    if (wr_en_c_i) m_c[wr][wc] = wr_data_i;
                end
                if (start_i) m_n = 0;
            end else if (m_n < D3) begin
                mi = m_n / (DIM * DIM);
                mj = (m_n / DIM) % DIM;
                mk = m_n % DIM;
                m_c[mi][mj] = m_c[mi][mj] + m_a[mi][mk] * m_b[mk][mj];
                m_n = m_n + 1;
            end else begin
                m_n = -1;
            end
            exp_busy = (m_n >= 0);
            exp_done = (m_n == D3);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk_i) begin
        if (rst_n_i && model_ok) begin
            chk("busy_o", 32'(busy_o), 32'(exp_busy));
            chk("done_o", 32'(done_o), 32'(exp_done));
            chk("rd_data_o", rd_data_o, exp_rd);
        end
    end

    task automatic wr(input bit ea, input bit eb, input bit ec, input int r, input int c,
                      input logic [31:0] d);
        wr_en_a_i = ea; wr_en_b_i = eb; wr_en_c_i = ec;
        row_i = 5'(r); col_i = 5'(c); wr_data_i = d;
        @(negedge clk_i);
        wr_en_a_i = 0; wr_en_b_i = 0; wr_en_c_i = 0;
    endtask

    task automatic rd_chk(input string name, input int r, input int c, input logic [31:0] exp);
        rd_row_i = 5'(r); rd_col_i = 5'(c);
        @(negedge clk_i);
        chk(name, rd_data_o, exp);
    endtask

    // Watch a run starting at the first busy cycle; optional intrusion at cycle 10
    task automatic monitor(input bit intr, input string name);
        int bcnt, dcnt, done_at;
        bcnt = 0; dcnt = 0; done_at = -1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (busy_o) bcnt++;
            if (done_o) begin dcnt++; done_at = bcnt; end
            if (!busy_o) break;
            if (intr && cyc == 10) begin
                wr_en_a_i = 1; row_i = 0; col_i = 0; wr_data_i = 32'hDEAD; start_i = 1;
            end else begin
                wr_en_a_i = 0; start_i = 0;
            end
            @(negedge clk_i);
        end
        wr_en_a_i = 0; start_i = 0;
        chk({name, " busy cycles"}, 32'(bcnt), 32'(D3 + 1));
        chk({name, " done pulses"}, 32'(dcnt), 32'd1);
        chk({name, " done in last busy cycle"}, 32'(done_at), 32'(D3 + 1));
    endtask

    task automatic start_run(input bit intr, input string name);
        start_i = 1;
        @(negedge clk_i);
        start_i = 0;
        monitor(intr, name);
    endtask

    task automatic do_reset();
        rst_n_i = 0;
        @(negedge clk_i);
        rst_n_i = 1;
        @(negedge clk_i);
    endtask

    initial begin
        #2 rst_n_i = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("reset busy_o", 32'(busy_o), 32'd0);
        chk("reset done_o", 32'(done_o), 32'd0);
        chk("reset rd_data_o", rd_data_o, 32'd0);
        rst_n_i = 1;
        @(negedge clk_i);

        // Identity: A = I, B[r][c] = 4r+c+1, with an ignored write/start mid-run
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                wr(1, 0, 0, r, c, (r == c) ? 32'd1 : 32'd0);
                wr(0, 1, 0, r, c, 32'(4 * r + c + 1));
            end
        start_run(1'b1, "identity");
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                rd_chk("identity C", r, c, 32'(4 * r + c + 1));

        // Out-of-range write is dropped and does not alias onto row 0
        wr(1, 0, 1, 4, 0, 32'd99);
        rd_chk("oob read row 4", 4, 0, 32'd0);
        rd_chk("oob no alias C[0][0]", 0, 0, 32'd1);

        // Accumulate: 10 + 4*2*3 = 34, then 58
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                wr(0, 0, 1, r, c, 32'd10);
                wr(1, 0, 0, r, c, 32'd2);
                wr(0, 1, 0, r, c, 32'd3);
            end
        start_run(1'b0, "accum1");
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                rd_chk("accum1 C", r, c, 32'd34);
        start_run(1'b0, "accum2");
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                rd_chk("accum2 C", r, c, 32'd58);

        // Wrap: 0x10000 * 0x10000 truncates to 0
        do_reset();
        wr(1, 1, 0, 0, 0, 32'h0001_0000);
        wr(0, 0, 1, 0, 0, 32'd5);
        start_run(1'b0, "wrap");
        rd_chk("wrap C[0][0]", 0, 0, 32'd5);

        // Simultaneous A/B write with start: the new values are used
        do_reset();
        wr_en_a_i = 1; wr_en_b_i = 1; row_i = 0; col_i = 0; wr_data_i = 32'd7; start_i = 1;
        @(negedge clk_i);
        wr_en_a_i = 0; wr_en_b_i = 0; start_i = 0;
        monitor(1'b0, "simul");
        rd_chk("simul C[0][0]", 0, 0, 32'd49);
        rd_chk("simul C[1][1]", 1, 1, 32'd0);

        // Reset 20 cycles into a run
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                wr(1, 1, 1, r, c, 32'd1);
        rd_row_i = 0; rd_col_i = 0;
        start_i = 1;
        @(negedge clk_i);
        start_i = 0;
        repeat (19) @(negedge clk_i);
        rst_n_i = 0;
        #1;
        chk("midreset busy_o", 32'(busy_o), 32'd0);
        chk("midreset done_o", 32'(done_o), 32'd0);
        chk("midreset rd_data_o", rd_data_o, 32'd0);
        @(negedge clk_i);
        rst_n_i = 1;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                rd_chk("post-reset C", r, c, 32'd0);
        start_run(1'b0, "post-reset run");

        // Random traffic checked cycle by cycle against the model
        for (int n = 0; n < 1500; n++) begin
            rd_row_i  = 5'($urandom_range(0, 5));
            rd_col_i  = 5'($urandom_range(0, 5));
            wr_en_a_i = ($urandom_range(0, 3) == 0);
            wr_en_b_i = ($urandom_range(0, 3) == 0);
            wr_en_c_i = ($urandom_range(0, 5) == 0);
            row_i     = 5'($urandom_range(0, 4));
            col_i     = 5'($urandom_range(0, 4));
            wr_data_i = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            start_i   = ($urandom_range(0, 39) == 0);
            @(negedge clk_i);
        end
        wr_en_a_i = 0; wr_en_b_i = 0; wr_en_c_i = 0; start_i = 0;
        repeat (80) @(negedge clk_i);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
